// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one load/enable counter among NREQ requesters.
// Define COUNTER_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module counter_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_start,
  input  logic [NREQ*WIDTH-1:0]   req_end,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    cnt_load,
  output logic [WIDTH-1:0]        cnt_load_val,
  output logic                    cnt_enable,
  input  logic [WIDTH-1:0]        cnt_value
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   win_q;
  logic [IDXW-1:0]   ptr_q;
  logic [WIDTH-1:0]  start_q;
  logic [WIDTH-1:0]  end_q;

  logic [IDXW-1:0]   pick;
  logic              found;
  int                idx;
  logic [WIDTH-1:0]  pickStart;
  logic [WIDTH-1:0]  pickEnd;
  logic              ownerReq;
  logic [IDXW-1:0]   nextPtr;
  logic [NREQ-1:0]   winOneHot;

  // First asserted request found scanning upward from the search origin.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr_q) + k) % NREQ;
`endif
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDXW'(idx);
      end
    end
  end

  assign pickStart = req_start[int'(pick)*WIDTH +: WIDTH];
  assign pickEnd   = req_end[int'(pick)*WIDTH +: WIDTH];
  assign ownerReq  = req[win_q];

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  assign nextPtr = '0;
`else
  assign nextPtr = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`endif

  // Dropping the owner's request in LOAD or RUN aborts the job without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            win_q   <= pick;
            start_q <= pickStart;
            end_q   <= pickEnd;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!ownerReq) begin
            ptr_q   <= nextPtr;
            state_q <= IDLE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!ownerReq) begin
            ptr_q   <= nextPtr;
            state_q <= IDLE;
          end else if (cnt_value == end_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= nextPtr;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign winOneHot    = NREQ'(1) << win_q;
  assign gnt          = (state_q != IDLE) ? winOneHot : '0;
  assign done         = (state_q == DONE) ? winOneHot : '0;
  assign busy         = (state_q != IDLE);
  assign cnt_load     = (state_q == LOAD);
  assign cnt_load_val = start_q;
  // Combinational so the counter stops on exactly the end value.
  assign cnt_enable   = (state_q == RUN) && (cnt_value != end_q);

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed vectors, corner sequences and a
// randomized job mix checked against a job-level scheduling model.
module tb_counter_sched;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  reqVec;
  logic [31:0] reqStart;
  logic [31:0] reqEnd;
  logic [3:0]  gntVec;
  logic [3:0]  doneVec;
  logic        busy;
  logic        cntLoad;
  logic [7:0]  cntLoadVal;
  logic        cntEnable;
  logic [7:0]  cntValue = 8'd0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         reqIdx;
    logic [7:0] startVal;
    logic [7:0] endVal;
    int         expDoneCycle;
    int         expEnCycles;
  } vector_t;

  vector_t vectors[5];

  counter_sched #(.NREQ(4), .WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .req          (reqVec),
    .req_start    (reqStart),
    .req_end      (reqEnd),
    .gnt          (gntVec),
    .done         (doneVec),
    .busy         (busy),
    .cnt_load     (cntLoad),
    .cnt_load_val (cntLoadVal),
    .cnt_enable   (cntEnable),
    .cnt_value    (cntValue)
  );

  always #5 clk = ~clk;

  // The shared load/enable counter the scheduler drives; it has no reset of its own.
  always @(posedge clk) begin
    if (cntLoad) cntValue <= cntLoadVal;
    else if (cntEnable) cntValue <= cntValue + 8'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic on, input logic [7:0] s, input logic [7:0] e);
    reqVec[idx]          = on;
    reqStart[idx*8 +: 8] = s;
    reqEnd[idx*8 +: 8]   = e;
  endtask

  // Job-level reference: which pending requester the arbiter should choose.
  function automatic int modelPick(input logic [3:0] pend, input int ptr);
    int i;
    for (int k = 0; k < 4; k++) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
      i = k;
`else
      i = (ptr + k) % 4;
`endif
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic resetDut();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge while idle: that cycle is cycle 0 of the job.
  task automatic runVector(input vector_t v);
    int doneCycle = -1;
    int enCount = 0;
    applyStimulus(v.reqIdx, 1'b1, v.startVal, v.endVal);
    for (int c = 1; c <= 300 && doneCycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("vecLoad", cntLoad, 1);
        checkOutput("vecLoadVal", cntLoadVal, v.startVal);
        checkOutput("vecGnt", gntVec, 32'(1) << v.reqIdx);
      end
      if (cntEnable) enCount++;
      if (doneVec != 4'b0) begin
        doneCycle = c;
        checkOutput("vecDone", doneVec, 32'(1) << v.reqIdx);
        checkOutput("vecEndValue", cntValue, v.endVal);
      end
    end
    checkOutput("vecDoneCycle", doneCycle, v.expDoneCycle);
    checkOutput("vecEnCycles", enCount, v.expEnCycles);
    applyStimulus(v.reqIdx, 1'b0, v.startVal, v.endVal);
    @(negedge clk);
    checkOutput("vecGntClear", gntVec, 0);
    checkOutput("vecBusyClear", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int grants[5];
    int expGrants[5];
    int nGrants;
    int waitCount;
    logic sawDone;
    logic [3:0] pending;
    int modelPtr;
    int w;
    int steps;
    logic [7:0] jobStart[4];
    logic [7:0] jobEnd[4];

    vectors[0] = '{0, 8'd10,  8'd15, 8,  5};
    vectors[1] = '{1, 8'd250, 8'd3,  12, 9};
    vectors[2] = '{2, 8'd77,  8'd77, 3,  0};
    vectors[3] = '{3, 8'd0,   8'd1,  4,  1};
    vectors[4] = '{0, 8'd255, 8'd0,  4,  1};

    rstN     = 1'b0;
    reqVec   = 4'b0;
    reqStart = 32'b0;
    reqEnd   = 32'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstGnt", gntVec, 0);
    checkOutput("rstDone", doneVec, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLoad", cntLoad, 0);
    checkOutput("rstLoadVal", cntLoadVal, 0);
    checkOutput("rstEnable", cntEnable, 0);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 5; i++) runVector(vectors[i]);

    $display("[TB] reset mid-run");
    applyStimulus(0, 1'b1, 8'd0, 8'd200);
    repeat (4) @(negedge clk);
    checkOutput("midRunEnable", cntEnable, 1);
    rstN = 1'b0;
    #1;
    checkOutput("midRstGnt", gntVec, 0);
    checkOutput("midRstDone", doneVec, 0);
    checkOutput("midRstEnable", cntEnable, 0);
    checkOutput("midRstBusy", busy, 0);
    applyStimulus(0, 1'b0, 8'd0, 8'd200);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    sawDone = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (doneVec != 4'b0 || busy) sawDone = 1'b1;
    end
    checkOutput("postRstQuiet", sawDone, 0);

    $display("[TB] contention");
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    expGrants = '{0, 0, 0, 0, 0};
`else
    expGrants = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 8'(40 + i), 8'(40 + i));
    nGrants = 0;
    for (int c = 0; c < 60 && nGrants < 5; c++) begin
      @(negedge clk);
      if (cntLoad) begin
        grants[nGrants] = $clog2(int'(gntVec));
        nGrants++;
      end
    end
    checkOutput("contGrantCount", nGrants, 5);
    for (int i = 0; i < nGrants; i++) checkOutput($sformatf("contGrant%0d", i), grants[i], expGrants[i]);
    reqVec = 4'b0;
    waitCount = 0;
    while (busy && waitCount < 10) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("contIdle", busy, 0);

    $display("[TB] abort");
    sawDone = 1'b0;
    applyStimulus(2, 1'b1, 8'd0, 8'd100);
    @(negedge clk);
    checkOutput("abortGnt", gntVec, 4'b0100);
    applyStimulus(3, 1'b1, 8'd5, 8'd6);
    repeat (3) begin
      @(negedge clk);
      if (doneVec[2]) sawDone = 1'b1;
    end
    applyStimulus(2, 1'b0, 8'd0, 8'd100);
    @(negedge clk);
    checkOutput("abortIdleGnt", gntVec, 0);
    checkOutput("abortIdleEnable", cntEnable, 0);
    checkOutput("abortIdleBusy", busy, 0);
    checkOutput("abortFrozen", cntValue, 3);
    if (doneVec[2]) sawDone = 1'b1;
    @(negedge clk);
    checkOutput("abortNextGnt", gntVec, 4'b1000);
    checkOutput("abortNextLoad", cntLoad, 1);
    checkOutput("abortHeld", cntValue, 3);
    repeat (3) begin
      @(negedge clk);
      if (doneVec[2]) sawDone = 1'b1;
    end
    checkOutput("abortReq3Done", doneVec, 4'b1000);
    checkOutput("abortNoDone2", sawDone, 0);
    applyStimulus(3, 1'b0, 8'd5, 8'd6);
    @(negedge clk);

    $display("[TB] randomized jobs");
    resetDut();
    modelPtr = 0;
    for (int r = 0; r < 10; r++) begin
      pending = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        if (pending[i]) begin
          jobStart[i] = 8'($urandom_range(0, 255));
          jobEnd[i]   = jobStart[i] + 8'($urandom_range(0, 12));
          applyStimulus(i, 1'b1, jobStart[i], jobEnd[i]);
        end
      end
      while (pending != 4'b0) begin
        w = modelPick(pending, modelPtr);
        steps = int'(8'(jobEnd[w] - jobStart[w]));
        for (int c = 1; c <= 3 + steps; c++) begin
          @(negedge clk);
          checkOutput("rndGnt", gntVec, 32'(1) << w);
          if (c == 1) checkOutput("rndLoadVal", cntLoadVal, jobStart[w]);
          if (c == 3 + steps) begin
            checkOutput("rndDone", doneVec, 32'(1) << w);
            checkOutput("rndEndValue", cntValue, jobEnd[w]);
          end else begin
            checkOutput("rndNoDone", doneVec, 0);
          end
        end
        applyStimulus(w, 1'b0, jobStart[w], jobEnd[w]);
        pending[w] = 1'b0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
        modelPtr = (w + 1) % 4;
`endif
        @(negedge clk);
        checkOutput("rndIdle", busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
